restoring_divider: RTL and testbench

- Multi-cycle unsigned integer divider for the arithmetic accelerator.
- It is the inverse datapath of the adder chain. It computes quotient and remainder by repeated subtraction, one quotient bit per clock.
- Each subtraction is performed by a carry-lookahead subtractor: inverted divisor, carry-in = 1.
- Operands enter on a valid/ready request port; results leave on a valid/ready response port. The block sits beside the adder units behind the accelerator operand mux.

---
 rtl/arith_pkg.sv | 11 +
 rtl/cla_subtractor.sv | 37 +++
 rtl/restoring_divider.sv | 104 ++++++++++
 tb/tb_restoring_divider.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared types and helpers for the arithmetic accelerator datapaths.
package arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} div_state_t;
  // Low w bits set; callers take the slice they need.
  function automatic logic [63:0] DIV_ZERO_QUOTIENT(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/cla_subtractor.sv
// cla_subtractor: iA - iB via 4-bit carry-lookahead groups with rippled group carries.
module cla_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oDiff,
  output logic             oNoBorrow
);
  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;
  logic [PW-1:0] a_p, b_p;
  logic [NG:0]   cc;
  // Pad bits give p=1, g=0, so the carry passes through them unchanged.
  assign a_p = PW'(iA);
  assign b_p = ~PW'(iB);
  assign cc[0] = 1'b1;
  assign oNoBorrow = cc[NG];
  for (genvar i = 0; i < NG; i++) begin : g_grp
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a_p[4*i +: 4] & b_p[4*i +: 4];
    assign p = a_p[4*i +: 4] ^ b_p[4*i +: 4];
    assign c[0] = cc[i];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign cc[i+1] = c[4];
    for (genvar j = 0; j < 4; j++) begin : g_bit
      if (4*i + j < WIDTH) begin : g_sum
        assign oDiff[4*i + j] = p[j] ^ c[j];
      end
    end
  end
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned divider, one quotient bit per clock,
// valid/ready on both request and response sides.
module restoring_divider
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [DATA_WIDTH-1:0] iDividend,
  input  logic [DATA_WIDTH-1:0] iDivisor,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oQuotient,
  output logic [DATA_WIDTH-1:0] oRemainder,
  output logic                  oDivByZero,
  output logic                  oBusy
);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [63:0] ZQ = DIV_ZERO_QUOTIENT(DATA_WIDTH);
  div_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d, nb;
  logic [DATA_WIDTH:0] rs, diff;
  logic unused_diff_msb;
  assign rs = {r_q, q_q[DATA_WIDTH-1]};
  // Partial remainder stays below the divisor, so the diff MSB is always 0 when kept.
  assign unused_diff_msb = diff[DATA_WIDTH];
  cla_subtractor #(.WIDTH(DATA_WIDTH + 1)) u_sub (
    .iA       (rs),
    .iB       ({1'b0, d_q}),
    .oDiff    (diff),
    .oNoBorrow(nb)
  );
  assign oReady     = (state_q == IDLE) && iRstN;
  assign oValid     = state_q == DONE;
  assign oBusy      = state_q != IDLE;
  assign oQuotient  = quo_q;
  assign oRemainder = rem_q;
  assign oDivByZero = dbz_q;
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (iValid) begin
        if (iDivisor == '0) begin
          state_d = DONE;
          quo_d   = ZQ[DATA_WIDTH-1:0];
          rem_d   = iDividend;
          dbz_d   = 1'b1;
        end else begin
          state_d = CALC;
          q_d     = iDividend;
          r_d     = '0;
          d_d     = iDivisor;
          cnt_d   = CW'(DATA_WIDTH - 1);
          dbz_d   = 1'b0;
        end
      end
      CALC: begin
        q_d   = {q_q[DATA_WIDTH-2:0], nb};
        r_d   = nb ? diff[DATA_WIDTH-1:0] : rs[DATA_WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_d;
        end
      end
      DONE: state_d = iReady ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors plus a short invariant sweep for restoring_divider.
module tb_restoring_divider;
  logic       iClk = 1'b0, iRstN = 1'b0, iValid = 1'b0, iReady = 1'b1;
  logic [7:0] iDividend = '0, iDivisor = '0;
  logic       oReady, oValid, oDivByZero, oBusy;
  logic [7:0] oQuotient, oRemainder;
  int n_cmp = 0, n_bad = 0;

  restoring_divider #(.DATA_WIDTH(8)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iValid    (iValid),
    .oReady    (oReady),
    .iDividend (iDividend),
    .iDivisor  (iDivisor),
    .oValid    (oValid),
    .iReady    (iReady),
    .oQuotient (oQuotient),
    .oRemainder(oRemainder),
    .oDivByZero(oDivByZero),
    .oBusy     (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, output int lat);
    iDividend = a;
    iDivisor  = b;
    iValid    = 1'b1;
    tick();
    iValid = 1'b0;
    lat = 0;
    while (!oValid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
    int lat;
    accept(a, b, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, oQuotient, eq);
    chk({tag, "_r"}, oRemainder, er);
    chk({tag, "_dbz"}, oDivByZero, ez);
    tick();
    chk({tag, "_valid_drop"}, oValid, 0);
    chk({tag, "_ready_back"}, oReady, 1);
  endtask

  initial begin
    int lat;
    logic [7:0] a, b;
    #2;
    chk("rst_ready", oReady, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_busy", oBusy, 0);
    tick();
    tick();
    iRstN = 1'b1;
    #1;
    chk("post_rst_ready", oReady, 1);
    chk("post_rst_q", oQuotient, 0);
    chk("post_rst_r", oRemainder, 0);

    run("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
    run("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
    run("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    run("d3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 8);
    run("d0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 8);
    run("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
    chk("idle_hold_q", oQuotient, 1);

    iReady = 1'b0;
    iDividend = 8'd100;
    iDivisor  = 8'd3;
    iValid    = 1'b1;
    tick();
    chk("bp_busy", oBusy, 1);
    chk("bp_not_ready", oReady, 0);
    iDividend = 8'd9;
    iDivisor  = 8'd0;
    lat = 0;
    while (!oValid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      iDividend = 8'(i * 37);
      iDivisor  = 8'(i + 2);
      iValid    = i[0];
      chk("bp_valid", oValid, 1);
      chk("bp_q", oQuotient, 33);
      chk("bp_r", oRemainder, 1);
      tick();
    end
    iValid = 1'b0;
    iReady = 1'b1;
    chk("bp_valid_last", oValid, 1);
    tick();
    chk("bp_valid_drop", oValid, 0);
    chk("bp_ready_back", oReady, 1);

    iDividend = 8'd77;
    iDivisor  = 8'd5;
    iValid    = 1'b1;
    tick();
    iValid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    iRstN = 1'b0;
    #1;
    chk("arst_valid", oValid, 0);
    chk("arst_q", oQuotient, 0);
    chk("arst_r", oRemainder, 0);
    chk("arst_busy", oBusy, 0);
    chk("arst_ready", oReady, 0);
    chk("arst_dbz", oDivByZero, 0);
    tick();
    iRstN = 1'b1;
    #1;
    run("d77_5", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 8);

    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      accept(a, b, lat);
      if (b == 0) begin
        chk("rnd_z_q", oQuotient, 8'hFF);
        chk("rnd_z_r", oRemainder, a);
        chk("rnd_z_dbz", oDivByZero, 1);
      end else begin
        chk("rnd_qdr", 32'(oQuotient) * 32'(b) + 32'(oRemainder), 32'(a));
        chk("rnd_r_lt_d", 32'(oRemainder < b), 1);
        chk("rnd_dbz", oDivByZero, 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
